// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between a writer and a reader.
// One transaction at a time, with watchdogs on the handshake and burst phases.
module mem_port_arbiter #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 16,
    parameter int BURST_MAX  = 256,
    parameter int HS_TIMEOUT = 1023
) (
    input  logic              mem_clk,
    input  logic              reset,
    input  logic              ctrlr_good,

    input  logic              w_req,
    input  logic              w_burst,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_grant,
    output logic              w_op_begun,
    output logic              w_data_ok,

    input  logic              r_req,
    input  logic              r_burst,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_grant,
    output logic              r_op_begun,
    output logic              r_data_ok,
    output logic [DATA_W-1:0] r_data,

    output logic              ctrl_wr,
    output logic              ctrl_rd,
    output logic              ctrl_burst,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [DATA_W-1:0] ctrl_wdata,
    input  logic              ctrl_op_begun,
    input  logic              ctrl_data_ok,
    input  logic [DATA_W-1:0] ctrl_rdata,

    output logic              err_timeout,
    output logic              err_overrun
);

    localparam int BCW = $clog2(BURST_MAX + 1);
    localparam int HCW = $clog2(HS_TIMEOUT + 1);
    localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_MAX - 1);
    localparam logic [HCW-1:0] HS_LAST    = HCW'(HS_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CMD,
        ST_WAIT_DATA,
        ST_BURST,
        ST_TURN
    } state_t;

    state_t         state_q, state_d;
    logic           gnt_w_q, gnt_w_d;
    logic           gnt_r_q, gnt_r_d;
    logic           last_r_q, last_r_d;
    logic           abort_q, abort_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic [HCW-1:0] hs_cnt_q, hs_cnt_d;
    logic           err_timeout_q, err_timeout_d;
    logic           err_overrun_q, err_overrun_d;

    logic req_g;
    logic burst_g;
    logic active;

    assign req_g   = gnt_w_q ? w_req : r_req;
    assign burst_g = gnt_w_q ? w_burst : r_burst;
    assign active  = (state_q == ST_CMD) || (state_q == ST_WAIT_DATA) || (state_q == ST_BURST);

    always_comb begin
        state_d       = state_q;
        gnt_w_d       = gnt_w_q;
        gnt_r_d       = gnt_r_q;
        last_r_d      = last_r_q;
        abort_d       = abort_q;
        burst_cnt_d   = '0;
        hs_cnt_d      = '0;
        err_timeout_d = err_timeout_q;
        err_overrun_d = err_overrun_q;

        if (!ctrlr_good) begin
            state_d = ST_INIT;
            gnt_w_d = 1'b0;
            gnt_r_d = 1'b0;
            abort_d = 1'b0;
        end else begin
            case (state_q)
                ST_INIT: state_d = ST_IDLE;
                ST_IDLE: begin
                    abort_d = 1'b0;
                    // On a tie the port that was not served last wins.
                    if (w_req && (!r_req || last_r_q)) begin
                        gnt_w_d = 1'b1;
                        state_d = ST_CMD;
                    end else if (r_req) begin
                        gnt_r_d = 1'b1;
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (ctrl_op_begun) begin
                        state_d = ST_WAIT_DATA;
                    end else if (!req_g) begin
                        abort_d = 1'b1;
                        state_d = ST_TURN;
                    end else if (hs_cnt_q == HS_LAST) begin
                        err_timeout_d = 1'b1;
                        state_d       = ST_TURN;
                    end else begin
                        hs_cnt_d = hs_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_DATA: begin
                    if (ctrl_data_ok) begin
                        state_d = ST_BURST;
                    end else if (hs_cnt_q == HS_LAST) begin
                        err_timeout_d = 1'b1;
                        state_d       = ST_TURN;
                    end else begin
                        hs_cnt_d = hs_cnt_q + 1'b1;
                    end
                end
                ST_BURST: begin
                    if (!burst_g) begin
                        state_d = ST_TURN;
                    end else if (burst_cnt_q == BURST_LAST) begin
                        err_overrun_d = 1'b1;
                        state_d       = ST_TURN;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
                ST_TURN: begin
                    // An aborted command does not count as service.
                    if (!abort_q) begin
                        last_r_d = gnt_r_q;
                    end
                    gnt_w_d = 1'b0;
                    gnt_r_d = 1'b0;
                    abort_d = 1'b0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge mem_clk) begin
        if (reset) begin
            state_q       <= ST_INIT;
            gnt_w_q       <= 1'b0;
            gnt_r_q       <= 1'b0;
            last_r_q      <= 1'b1;
            abort_q       <= 1'b0;
            burst_cnt_q   <= '0;
            hs_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_w_q       <= gnt_w_d;
            gnt_r_q       <= gnt_r_d;
            last_r_q      <= last_r_d;
            abort_q       <= abort_d;
            burst_cnt_q   <= burst_cnt_d;
            hs_cnt_q      <= hs_cnt_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign w_grant     = gnt_w_q;
    assign r_grant     = gnt_r_q;
    assign w_op_begun  = gnt_w_q & ctrl_op_begun;
    assign w_data_ok   = gnt_w_q & ctrl_data_ok;
    assign r_op_begun  = gnt_r_q & ctrl_op_begun;
    assign r_data_ok   = gnt_r_q & ctrl_data_ok;
    assign r_data      = ctrl_rdata;

    assign ctrl_wr     = (state_q == ST_CMD) & gnt_w_q & w_req;
    assign ctrl_rd     = (state_q == ST_CMD) & gnt_r_q & r_req;
    assign ctrl_burst  = (state_q == ST_BURST) & burst_g;
    assign ctrl_addr   = !active ? '0 : (gnt_w_q ? w_addr : r_addr);
    assign ctrl_wdata  = (active && gnt_w_q) ? w_data : '0;

    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;

endmodule
